// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice per stage, rippling the
// registered carry forward while the untouched operand slices travel alongside.
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int GROUPS = CHUNK / 4;
   localparam int LAST   = STAGES - 1;

   generate
      if (CHUNK < 4 || (CHUNK % 4) != 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
         $error("cla_pipe_adder: CHUNK must be a multiple of 4 and WIDTH a multiple of CHUNK");
      end
   endgenerate

   // Returns {carry_out, chunk_sum}; 4-bit lookahead groups chained inside the chunk.
   function automatic logic [CHUNK:0] cla_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             ci);
      logic [CHUNK-1:0] g;
      logic [CHUNK-1:0] p;
      logic [CHUNK:0]   c;
      int               k;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int grp = 0; grp < GROUPS; grp++) begin
         k = grp * 4;
         c[k+1] = g[k] | (p[k] & c[k]);
         c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
         c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                | (p[k+2] & p[k+1] & p[k] & c[k]);
         c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
                | (p[k+3] & p[k+2] & p[k+1] & g[k])
                | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
      end
      return {c[CHUNK], p ^ c[CHUNK-1:0]};
   endfunction

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   logic             vld_q  [STAGES];
   logic             vld_d  [STAGES];
   logic [WIDTH-1:0] opa_q  [STAGES];
   logic [WIDTH-1:0] opa_d  [STAGES];
   logic [WIDTH-1:0] opb_q  [STAGES];
   logic [WIDTH-1:0] opb_d  [STAGES];
   logic [WIDTH-1:0] res_q  [STAGES];
   logic [WIDTH-1:0] res_d  [STAGES];
   logic             cy_q   [STAGES];
   logic             cy_d   [STAGES];
   logic             amsb_q [STAGES];
   logic             amsb_d [STAGES];
   logic             bmsb_q [STAGES];
   logic             bmsb_d [STAGES];

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv      = !vld_q[LAST] || out_ready;
   assign in_ready = adv;
   assign b_eff    = sub ? ~b : b;
   assign c_eff    = sub ? 1'b1 : cin;

   always_comb begin : stage_next
      logic [CHUNK:0] r;
      r         = cla_chunk(a[CHUNK-1:0], b_eff[CHUNK-1:0], c_eff);
      vld_d[0]  = in_valid;
      opa_d[0]  = a;
      opb_d[0]  = b_eff;
      res_d[0]  = '0;
      res_d[0][CHUNK-1:0] = r[CHUNK-1:0];
      cy_d[0]   = r[CHUNK];
      amsb_d[0] = a[WIDTH-1];
      bmsb_d[0] = b_eff[WIDTH-1];
      for (int s = 1; s < STAGES; s++) begin
         r         = cla_chunk(opa_q[s-1][s*CHUNK +: CHUNK], opb_q[s-1][s*CHUNK +: CHUNK],
                               cy_q[s-1]);
         vld_d[s]  = vld_q[s-1];
         opa_d[s]  = opa_q[s-1];
         opb_d[s]  = opb_q[s-1];
         res_d[s]  = res_q[s-1];
         res_d[s][s*CHUNK +: CHUNK] = r[CHUNK-1:0];
         cy_d[s]   = r[CHUNK];
         amsb_d[s] = amsb_q[s-1];
         bmsb_d[s] = bmsb_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= 1'b0;
            opa_q[s]  <= '0;
            opb_q[s]  <= '0;
            res_q[s]  <= '0;
            cy_q[s]   <= 1'b0;
            amsb_q[s] <= 1'b0;
            bmsb_q[s] <= 1'b0;
         end
      end else if (adv) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= vld_d[s];
            opa_q[s]  <= opa_d[s];
            opb_q[s]  <= opb_d[s];
            res_q[s]  <= res_d[s];
            cy_q[s]   <= cy_d[s];
            amsb_q[s] <= amsb_d[s];
            bmsb_q[s] <= bmsb_d[s];
         end
      end
   end

   assign out_valid = vld_q[LAST];
   assign sum       = res_q[LAST];
   assign cout      = cy_q[LAST];
   assign ovf       = (amsb_q[LAST] == bmsb_q[LAST]) && (res_q[LAST][WIDTH-1] != amsb_q[LAST]);
   // Gated by valid so an empty pipe (all-zero sum) does not report zero.
   assign zero      = vld_q[LAST] && (res_q[LAST] == '0);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed vectors, stall, mid-flight reset, random traffic.
module tb_cla_pipe_adder;

   localparam int W  = 32;
   localparam int ST = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout, ovf, zero;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
      bit           lat;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   stall_cnt = 0;
   bit   rnd_mode  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input logic ms);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   t;
      be    = ms ? ~mb : mb;
      t     = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
      e.s   = t[W-1:0];
      e.c   = t[W];
      e.o   = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
      e.z   = (t[W-1:0] == '0);
      e.lat = 0;
      e.acc = cyc;
      return e;
   endfunction

   // Random-phase acceptance: expected value pushed when the beat is taken.
   always @(negedge clk) begin : in_mon
      exp_t e;
      if (rnd_mode && rst_n && in_valid && in_ready) begin
         e = model(a, b, cin, sub);
         exp_q.push_back(e);
      end
   end

   logic         stall_prev = 0;
   logic [W-1:0] h_sum;
   logic [2:0]   h_flags;

   always @(negedge clk) begin : out_mon
      exp_t e;
      if (!rst_n) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_sum", {32'd0, sum}, {32'd0, h_sum});
            chk("hold_flags", {61'd0, cout, ovf, zero}, {61'd0, h_flags});
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            stall_cnt++;
            stall_prev = 1;
            h_sum      = sum;
            h_flags    = {cout, ovf, zero};
         end else begin
            stall_prev = 0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual=0x%0h required=no result", sum);
            end else begin
               e = exp_q.pop_front();
               chk("sum", {32'd0, sum}, {32'd0, e.s});
               chk("cout", {63'd0, cout}, {63'd0, e.c});
               chk("ovf", {63'd0, ovf}, {63'd0, e.o});
               chk("zero", {63'd0, zero}, {63'd0, e.z});
               if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(ST));
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 after the beat has been taken.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic ez, input bit lat);
      exp_t e;
      int   n;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready 0 required=in_ready 1");
      end else begin
         e.s = es; e.c = ec; e.o = eo; e.z = ez; e.lat = lat; e.acc = cyc;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_sum", {32'd0, sum}, 64'd0);
      chk("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back directed vectors, each with latency checked.
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
      send(32'd5,         32'd3,         1'b1, 1'b0, 32'd9,         1'b0, 1'b0, 1'b0, 1);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1);
      send(32'd3,         32'd5,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
      wait_idle();

      // Vectors separated by bubbles.
      send(32'd10,        32'd10,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1);
      @(posedge clk); #1;
      send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0, 1);
      @(posedge clk); #1;
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1);
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1);
      wait_idle();

      // Six back-to-back beats with out_ready low for three cycles on the first result.
      stall_cnt = 0;
      fork
         begin
            send(32'd1,         32'd1,         1'b0, 1'b0, 32'd2,         1'b0, 1'b0, 1'b0, 0);
            send(32'h0000_FFFF, 32'd1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 0);
            send(32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b0, 32'h0000_01FE, 1'b0, 1'b0, 1'b0, 0);
            send(32'd100,       32'd1,         1'b0, 1'b1, 32'd99,        1'b1, 1'b0, 1'b0, 0);
            send(32'd0,         32'd1,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
            send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("stall_cycles", 64'(stall_cnt), 64'd3);

      // Reset with three beats in flight, the oldest already at the output.
      send(32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 0);
      send(32'd4, 32'd5, 1'b0, 1'b0, 32'd9, 1'b0, 1'b0, 1'b0, 0);
      send(32'd6, 32'd7, 1'b0, 1'b0, 32'd13, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_sum", {32'd0, sum}, 64'd0);
      chk("midrst_flags", {61'd0, cout, ovf, zero}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1);
      wait_idle();

      // Random traffic with random backpressure against the arithmetic model.
      rnd_mode = 1;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         b         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rnd_mode  = 0;
      wait_idle();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
